// File: rtl/forward_select_unit.sv
// -----------------------------------------------------------------------------
// forward_select_unit
//
// Purpose:
//   Produces the 2-bit operand-select codes for the EX-stage 3-to-1 operand
//   muxes of the pipelined CPU, plus the load-use stall request. A shadow
//   pipeline of destination-register records (EX, MEM, WB) is fed from the
//   ID-stage decode. The select codes are registered at the ID->EX boundary,
//   so they are stable for the whole EX cycle of the instruction they belong
//   to.
//
//   Select encoding (matches the mux data inputs):
//     00 = register-file data, 01 = MEM/WB writeback data,
//     10 = EX/MEM ALU result,  11 = never driven.
//
// Ports:
//   clk_i          in   clock, rising edge
//   rst_i          in   synchronous, active-high reset
//   id_rs_i        in   source register A of the instruction in ID
//   id_rt_i        in   source register B of the instruction in ID
//   id_rd_i        in   destination register of the instruction in ID
//   id_regwrite_i  in   instruction in ID writes the register file
//   id_memread_i   in   instruction in ID is a load
//   flush_i        in   squash the instruction in ID
//   forward_a_o    out  select code for the operand-A mux in EX
//   forward_b_o    out  select code for the operand-B mux in EX
//   stall_o        out  hold PC and IF/ID (combinational)
// -----------------------------------------------------------------------------
module forward_select_unit #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        forward_a_o,
    output logic [1:0]        forward_b_o,
    output logic              stall_o
);

    localparam logic [REG_AW-1:0] ZERO = REG_AW'(ZERO_REG);

    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_WB      = 2'b01;
    localparam logic [1:0] SEL_EXMEM   = 2'b10;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } rec_t;

    localparam rec_t BUBBLE = '{rd: '0, regwrite: 1'b0, memread: 1'b0};

    rec_t ex_r;
    rec_t mem_r;
    rec_t wb_r;

    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    // A producer only matters if it actually writes, and the zero register
    // is hard-wired so it is never a forwarding target.
    function automatic logic hz(input rec_t rec, input logic [REG_AW-1:0] s);
        return rec.regwrite && (rec.rd == s) && (s != ZERO);
    endfunction

    // Nearest producer wins: ex_r will sit in MEM during the consumer's EX,
    // mem_r will sit in WB. wb_r is already written back (write-first
    // register file), so it is never a source.
    function automatic logic [1:0] fwd_code(input rec_t ex, input rec_t mem,
                                            input logic [REG_AW-1:0] s);
        if (hz(ex, s))       return SEL_EXMEM;
        else if (hz(mem, s)) return SEL_WB;
        else                 return SEL_REGFILE;
    endfunction

    // A load still in EX cannot supply its data in time for the next
    // instruction; holding ID for one cycle turns it into a 01 forward.
    assign stall_o = ex_r.memread && ex_r.regwrite && (ex_r.rd != ZERO) &&
                     ((ex_r.rd == id_rs_i) || (ex_r.rd == id_rt_i));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        fwd_a_next = SEL_REGFILE;
        fwd_b_next = SEL_REGFILE;
        if (!stall_o && !flush_i) begin
            fwd_a_next = fwd_code(ex_r, mem_r, id_rs_i);
            fwd_b_next = fwd_code(ex_r, mem_r, id_rt_i);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values (mem_r gets the old ex_r, not the new one).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_r        <= BUBBLE;
            mem_r       <= BUBBLE;
            wb_r        <= BUBBLE;
            forward_a_o <= SEL_REGFILE;
            forward_b_o <= SEL_REGFILE;
        end else begin
            mem_r       <= ex_r;
            wb_r        <= mem_r;
            forward_a_o <= fwd_a_next;
            forward_b_o <= fwd_b_next;
            if (stall_o || flush_i) begin
                ex_r <= BUBBLE;
            end else begin
                ex_r <= '{rd: id_rd_i, regwrite: id_regwrite_i,
                          memread: id_memread_i};
            end
        end
    end

    // The WB record exists only for debug observation; this reduction keeps
    // it referenced without it driving any output.
    logic unused_wb;
    assign unused_wb = ^wb_r;

endmodule
